maze_engine: RTL and testbench

// - Parametrised maze-game core for the LED-matrix/keypad lab platform.
// - Holds the player position as binary (x,y) coordinates and checks walls against a level ROM.
// - Sequences N_LEVELS maps and handles crash/win states.
// - Produces row-scan red/green drive for the GRID x GRID dot matrix.
// - Sits after the keypad decode/debounce chain; its row/red/green outputs go straight to the matrix pins.

---
 rtl/maze_pkg.sv | 65 ++++++
 rtl/maze_map_rom.sv | 59 +++++
 rtl/maze_engine.sv | 187 ++++++++++++++++++
 tb/tb_maze_engine.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze game core: move directions, FSM states,
// the default 8x8 level tables and the win-screen smiley.
package maze_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_CHECK,
    ST_CRASH,
    ST_WIN
  } state_t;

  localparam int unsigned DEF_MAPS = 2;

  // Wall rows, index [map][y]; bit 7 is column x=0.
  localparam logic [7:0] DEF_WALLS [DEF_MAPS][8] = '{
    '{8'b0001_0000, 8'b0101_0110, 8'b0100_0000, 8'b0111_1100,
      8'b0000_0100, 8'b1110_0101, 8'b0000_0001, 8'b0111_1000},
    '{8'b0010_0000, 8'b0010_1110, 8'b1000_0010, 8'b1011_1010,
      8'b0000_1000, 8'b0110_1011, 8'b0100_0000, 8'b0001_0100}
  };

  localparam int unsigned DEF_START_X [DEF_MAPS] = '{0, 0};
  localparam int unsigned DEF_START_Y [DEF_MAPS] = '{0, 7};
  localparam int unsigned DEF_GOAL_X  [DEF_MAPS] = '{7, 7};
  localparam int unsigned DEF_GOAL_Y  [DEF_MAPS] = '{7, 0};

  localparam logic [7:0] SMILEY [8] = '{
    8'h3C, 8'h42, 8'hA5, 8'h81, 8'hA5, 8'h99, 8'h42, 8'h3C
  };

  // Maps beyond the table, and grids other than 8x8, tile the default maps.
  function automatic logic def_wall(int unsigned lvl, int unsigned x, int unsigned y);
    logic [7:0] r;
    r = DEF_WALLS[1'(lvl % DEF_MAPS)][3'(y % 8)];
    return r[3'(7 - (x % 8))];
  endfunction

  function automatic logic def_smiley(int unsigned x, int unsigned y);
    logic [7:0] r;
    r = SMILEY[3'(y % 8)];
    return r[3'(7 - (x % 8))];
  endfunction

  function automatic int unsigned def_start_x(int unsigned lvl);
    return DEF_START_X[1'(lvl % DEF_MAPS)];
  endfunction

  function automatic int unsigned def_start_y(int unsigned lvl);
    return DEF_START_Y[1'(lvl % DEF_MAPS)];
  endfunction

  function automatic int unsigned def_goal_x(int unsigned lvl);
    return DEF_GOAL_X[1'(lvl % DEF_MAPS)];
  endfunction

  function automatic int unsigned def_goal_y(int unsigned lvl);
    return DEF_GOAL_Y[1'(lvl % DEF_MAPS)];
  endfunction

endpackage

// File: rtl/maze_map_rom.sv
// Combinational level ROM.
//   a_level/a_y -> a_row      : wall row for the move check
//   b_level/b_y -> b_row      : wall row for the display scan
//               -> b_smiley   : win pattern row for the display scan
//   s_level     -> start_x/y  : start cell
//   g_level     -> goal_x/y   : goal cell
module maze_map_rom
  import maze_pkg::*;
#(
  parameter int unsigned GRID     = 8,
  parameter int unsigned N_LEVELS = 2,
  localparam int unsigned W       = $clog2(GRID)
) (
  input  logic [2:0]      a_level,
  input  logic [W-1:0]    a_y,
  output logic [GRID-1:0] a_row,
  input  logic [2:0]      b_level,
  input  logic [W-1:0]    b_y,
  output logic [GRID-1:0] b_row,
  output logic [GRID-1:0] b_smiley,
  input  logic [2:0]      s_level,
  output logic [W-1:0]    start_x,
  output logic [W-1:0]    start_y,
  input  logic [2:0]      g_level,
  output logic [W-1:0]    goal_x,
  output logic [W-1:0]    goal_y
);

  if (GRID < 4 || GRID > 16 || (GRID & (GRID - 1)) != 0) begin : g_bad_grid
    $error("maze_map_rom: GRID must be a power of 2 in 4..16");
  end
  if (N_LEVELS < 1 || N_LEVELS > 8) begin : g_bad_levels
    $error("maze_map_rom: N_LEVELS must be in 1..8");
  end

  for (genvar l = 0; l < N_LEVELS; l++) begin : g_lvl
    if (def_wall(l, def_start_x(l) % GRID, def_start_y(l) % GRID) ||
        def_wall(l, def_goal_x(l) % GRID, def_goal_y(l) % GRID)) begin : g_bad_cell
      $error("maze_map_rom: level %0d has a start or goal cell on a wall", l);
    end
  end

  always_comb begin
    a_row    = '0;
    b_row    = '0;
    b_smiley = '0;
    for (int unsigned x = 0; x < GRID; x++) begin
      a_row[W'(GRID - 1 - x)]    = def_wall(32'(a_level), x, 32'(a_y));
      b_row[W'(GRID - 1 - x)]    = def_wall(32'(b_level), x, 32'(b_y));
      b_smiley[W'(GRID - 1 - x)] = def_smiley(x, 32'(b_y));
    end
  end

  assign start_x = W'(def_start_x(32'(s_level)) % GRID);
  assign start_y = W'(def_start_y(32'(s_level)) % GRID);
  assign goal_x  = W'(def_goal_x(32'(g_level)) % GRID);
  assign goal_y  = W'(def_goal_y(32'(g_level)) % GRID);

endmodule

// File: rtl/maze_engine.sv
// Maze game core: player position, wall check, level sequencing,
// crash/win handling and registered row-scan drive for the dot matrix.
//   clk, reset       : clock, synchronous active-high reset
//   scan_en          : display row advance / crash hold tick
//   move_valid/dir   : debounced key press and direction
//   row/red/green    : matrix drive, MSB = top row / left column
//   pos_x/pos_y/level: player state; crashed/won: state flags
module maze_engine
  import maze_pkg::*;
#(
  parameter int unsigned GRID       = 8,
  parameter int unsigned N_LEVELS   = 2,
  parameter int unsigned CRASH_HOLD = 0,
  parameter int unsigned WRAP       = 0,
  localparam int unsigned W         = $clog2(GRID)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            scan_en,
  input  logic            move_valid,
  input  logic [1:0]      move_dir,
  output logic [GRID-1:0] row,
  output logic [GRID-1:0] red,
  output logic [GRID-1:0] green,
  output logic [W-1:0]    pos_x,
  output logic [W-1:0]    pos_y,
  output logic [2:0]      level,
  output logic            crashed,
  output logic            won
);

  localparam int unsigned HW = (CRASH_HOLD > 1) ? $clog2(CRASH_HOLD) : 1;
  localparam logic [GRID-1:0] ROW_TOP  = {1'b1, {(GRID - 1){1'b0}}};
  localparam logic [W-1:0]    START0_X = W'(def_start_x(0) % GRID);
  localparam logic [W-1:0]    START0_Y = W'(def_start_y(0) % GRID);

  state_t          state_q, state_d;
  logic [2:0]      level_q, level_d;
  logic [W-1:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [W-1:0]    tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [W-1:0]    ridx_q, ridx_d;
  logic [GRID-1:0] row_q, row_d, red_q, red_d, green_q, green_d;

  logic [W-1:0]    mv_x, mv_y;
  logic [GRID-1:0] a_row, b_row, b_smiley;
  logic [2:0]      s_level;
  logic [W-1:0]    start_x, start_y, goal_x, goal_y;
  logic            wall_hit;

  // In CHECK the start lookup is for the next level, used on a goal hit.
  assign s_level  = (state_q == ST_CHECK) ? level_q + 3'd1 : level_q;
  assign wall_hit = |(a_row & (ROW_TOP >> tgt_x_q));

  maze_map_rom #(
    .GRID     (GRID),
    .N_LEVELS (N_LEVELS)
  ) u_rom (
    .a_level  (level_q),
    .a_y      (tgt_y_q),
    .a_row    (a_row),
    .b_level  (level_d),
    .b_y      (ridx_d),
    .b_row    (b_row),
    .b_smiley (b_smiley),
    .s_level  (s_level),
    .start_x  (start_x),
    .start_y  (start_y),
    .g_level  (level_q),
    .goal_x   (goal_x),
    .goal_y   (goal_y)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    hold_d  = hold_q;
    ridx_d  = scan_en ? ridx_q + 1'b1 : ridx_q;

    // Power-of-2 grid: plain W-bit arithmetic gives the wrap.
    mv_x = pos_x_q;
    mv_y = pos_y_q;
    case (move_dir)
      DIR_UP:    if (pos_y_q != '0 || WRAP != 0) mv_y = pos_y_q - 1'b1;
      DIR_DOWN:  if (pos_y_q != '1 || WRAP != 0) mv_y = pos_y_q + 1'b1;
      DIR_LEFT:  if (pos_x_q != '0 || WRAP != 0) mv_x = pos_x_q - 1'b1;
      default:   if (pos_x_q != '1 || WRAP != 0) mv_x = pos_x_q + 1'b1;
    endcase

    case (state_q)
      ST_PLAY: begin
        if (move_valid) begin
          tgt_x_d = mv_x;
          tgt_y_d = mv_y;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (wall_hit) begin
          state_d = ST_CRASH;
          hold_d  = '0;
        end else begin
          pos_x_d = tgt_x_q;
          pos_y_d = tgt_y_q;
          state_d = ST_PLAY;
          if (tgt_x_q == goal_x && tgt_y_q == goal_y) begin
            if (level_q == 3'(N_LEVELS - 1)) begin
              state_d = ST_WIN;
            end else begin
              level_d = level_q + 3'd1;
              pos_x_d = start_x;
              pos_y_d = start_y;
            end
          end
        end
      end
      ST_CRASH: begin
        if (CRASH_HOLD != 0 && scan_en) begin
          if (32'(hold_q) + 32'd1 == CRASH_HOLD) begin
            hold_d  = '0;
            pos_x_d = start_x;
            pos_y_d = start_y;
            state_d = ST_PLAY;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Display registers load from the next-state values so they track the
  // game state with no extra cycle of lag.
  always_comb begin
    row_d   = ROW_TOP >> ridx_d;
    red_d   = '0;
    green_d = b_row;
    case (state_d)
      ST_CRASH: green_d = '1;
      ST_WIN:   green_d = b_smiley;
      default:  if (ridx_d == pos_y_d) red_d = ROW_TOP >> pos_x_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PLAY;
      level_q <= '0;
      pos_x_q <= START0_X;
      pos_y_q <= START0_Y;
      tgt_x_q <= '0;
      tgt_y_q <= '0;
      hold_q  <= '0;
      ridx_q  <= '0;
      row_q   <= ROW_TOP;
      red_q   <= '0;
      green_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      tgt_x_q <= tgt_x_d;
      tgt_y_q <= tgt_y_d;
      hold_q  <= hold_d;
      ridx_q  <= ridx_d;
      row_q   <= row_d;
      red_q   <= red_d;
      green_q <= green_d;
    end
  end

  assign row     = row_q;
  assign red     = red_q;
  assign green   = green_q;
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign level   = level_q;
  assign crashed = (state_q == ST_CRASH);
  assign won     = (state_q == ST_WIN);

endmodule

// File: tb/tb_maze_engine.sv
module tb_maze_engine;
  import maze_pkg::*;

  localparam int NCYC  = 6000;
  localparam int N_LV  = 2;
  localparam int M_PLAY = 0, M_CHECK = 1, M_CRASH = 2, M_WIN = 3;
  localparam int HOLD_P [2] = '{4, 0};
  localparam int WRAP_P [2] = '{0, 1};
  localparam logic [7:0] SMILE_EXP [8] = '{
    8'h3C, 8'h42, 8'hA5, 8'h81, 8'hA5, 8'h99, 8'h42, 8'h3C
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i [2];
  logic       mv_i  [2];
  logic [1:0] dir_i [2];
  logic       scan_en;
  logic [7:0] row_o [2], red_o [2], green_o [2];
  logic [2:0] px_o [2], py_o [2], lvl_o [2];
  logic       cr_o [2], won_o [2];

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_st [2], m_x [2], m_y [2], m_lvl [2], m_tx [2], m_ty [2];
  int m_hold [2], m_ridx [2], stuck [2];
  bit m_blank [2];
  int n_win = 0, n_crash = 0, n_level = 0;

  initial begin
    rst_i[0] = 1'b1; rst_i[1] = 1'b1;
    mv_i[0] = 1'b0; mv_i[1] = 1'b0;
    dir_i[0] = 2'b00; dir_i[1] = 2'b00;
    scan_en = 1'b0;
  end

  maze_engine #(.GRID(8), .N_LEVELS(2), .CRASH_HOLD(4), .WRAP(0)) dut_a (
    .clk(clk), .reset(rst_i[0]), .scan_en(scan_en), .move_valid(mv_i[0]),
    .move_dir(dir_i[0]), .row(row_o[0]), .red(red_o[0]), .green(green_o[0]),
    .pos_x(px_o[0]), .pos_y(py_o[0]), .level(lvl_o[0]), .crashed(cr_o[0]),
    .won(won_o[0]));

  maze_engine #(.GRID(8), .N_LEVELS(2), .CRASH_HOLD(0), .WRAP(1)) dut_b (
    .clk(clk), .reset(rst_i[1]), .scan_en(scan_en), .move_valid(mv_i[1]),
    .move_dir(dir_i[1]), .row(row_o[1]), .red(red_o[1]), .green(green_o[1]),
    .pos_x(px_o[1]), .pos_y(py_o[1]), .level(lvl_o[1]), .crashed(cr_o[1]),
    .won(won_o[1]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_wall(int lvl, int x, int y);
    logic [7:0] r;
    r = DEF_WALLS[1'(lvl)][3'(y)];
    return r[3'(7 - x)];
  endfunction

  // Cell reached by a move from (x,y) on instance i.
  task automatic target(input int i, input int x, input int y, input logic [1:0] d,
                        output int nx, output int ny);
    nx = x; ny = y;
    case (d)
      2'b00: ny = y - 1;
      2'b01: ny = y + 1;
      2'b10: nx = x - 1;
      default: nx = x + 1;
    endcase
    if (nx < 0 || nx > 7 || ny < 0 || ny > 7) begin
      if (WRAP_P[i] != 0) begin
        nx = (nx + 8) % 8;
        ny = (ny + 8) % 8;
      end else begin
        nx = x;
        ny = y;
      end
    end
  endtask

  task automatic step(input int i, input bit rst, input bit v, input logic [1:0] d, input bit sc);
    int nx, ny;
    if (rst) begin
      m_st[i] = M_PLAY; m_lvl[i] = 0; m_hold[i] = 0; m_ridx[i] = 0;
      m_x[i] = int'(DEF_START_X[0]); m_y[i] = int'(DEF_START_Y[0]);
      m_blank[i] = 1'b1;
      return;
    end
    m_blank[i] = 1'b0;
    if (sc) m_ridx[i] = (m_ridx[i] + 1) % 8;
    case (m_st[i])
      M_PLAY: if (v) begin
        target(i, m_x[i], m_y[i], d, nx, ny);
        m_tx[i] = nx; m_ty[i] = ny; m_st[i] = M_CHECK;
      end
      M_CHECK: begin
        if (is_wall(m_lvl[i], m_tx[i], m_ty[i])) begin
          m_st[i] = M_CRASH; m_hold[i] = 0; n_crash++;
        end else begin
          m_x[i] = m_tx[i]; m_y[i] = m_ty[i]; m_st[i] = M_PLAY;
          if (m_tx[i] == int'(DEF_GOAL_X[1'(m_lvl[i])]) && m_ty[i] == int'(DEF_GOAL_Y[1'(m_lvl[i])])) begin
            if (m_lvl[i] == N_LV - 1) begin
              m_st[i] = M_WIN; n_win++;
            end else begin
              m_lvl[i]++; n_level++;
              m_x[i] = int'(DEF_START_X[1'(m_lvl[i])]);
              m_y[i] = int'(DEF_START_Y[1'(m_lvl[i])]);
            end
          end
        end
      end
      M_CRASH: if (HOLD_P[i] > 0 && sc) begin
        m_hold[i]++;
        if (m_hold[i] == HOLD_P[i]) begin
          m_hold[i] = 0; m_st[i] = M_PLAY;
          m_x[i] = int'(DEF_START_X[1'(m_lvl[i])]);
          m_y[i] = int'(DEF_START_Y[1'(m_lvl[i])]);
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare(input int i);
    logic [7:0] e_row, e_red, e_grn;
    string s;
    e_row = 8'h80 >> m_ridx[i];
    e_red = 8'h00;
    e_grn = 8'h00;
    if (!m_blank[i]) begin
      if (m_st[i] == M_CRASH) e_grn = 8'hFF;
      else if (m_st[i] == M_WIN) e_grn = SMILE_EXP[3'(m_ridx[i])];
      else begin
        for (int x = 0; x < 8; x++) e_grn[3'(7 - x)] = is_wall(m_lvl[i], x, m_ridx[i]);
        if (m_ridx[i] == m_y[i]) e_red = 8'h80 >> m_x[i];
      end
    end
    s = (i == 0) ? "a" : "b";
    check_val({s, ".row"},     32'(row_o[i]),   32'(e_row));
    check_val({s, ".red"},     32'(red_o[i]),   32'(e_red));
    check_val({s, ".green"},   32'(green_o[i]), 32'(e_grn));
    check_val({s, ".pos_x"},   32'(px_o[i]),    32'(m_x[i]));
    check_val({s, ".pos_y"},   32'(py_o[i]),    32'(m_y[i]));
    check_val({s, ".level"},   32'(lvl_o[i]),   32'(m_lvl[i]));
    check_val({s, ".crashed"}, 32'(cr_o[i]),    32'(m_st[i] == M_CRASH));
    check_val({s, ".won"},     32'(won_o[i]),   32'(m_st[i] == M_WIN));
  endtask

  initial begin
    bit sc, r, v;
    logic [1:0] d;
    int nx, ny;
    stuck[0] = 0; stuck[1] = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        compare(0);
        compare(1);
      end
      sc = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 2; i++) begin
        r = (cyc < 2) || (stuck[i] > 40) || ($urandom_range(0, 1999) == 0);
        v = (m_st[i] == M_PLAY) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
        d = 2'($urandom_range(0, 3));
        // mostly steer away from walls so the goals are reached
        if ($urandom_range(0, 7) != 0) begin
          for (int k = 0; k < 6; k++) begin
            target(i, m_x[i], m_y[i], d, nx, ny);
            if (!is_wall(m_lvl[i], nx, ny)) break;
            d = 2'($urandom_range(0, 3));
          end
        end
        if (r) stuck[i] = 0;
        else if (m_st[i] == M_CRASH || m_st[i] == M_WIN) stuck[i]++;
        else stuck[i] = 0;
        step(i, r, v, d, sc);
        rst_i[i] = r;
        mv_i[i]  = v;
        dir_i[i] = d;
      end
      scan_en = sc;
    end
    $display("coverage: level_ups=%0d wins=%0d crashes=%0d", n_level, n_win, n_crash);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
